// File: rtl/counter_pkg.sv
// Shared constants for the parametrised counter family: overflow-mode
// encodings and the default counter width.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

endpackage

// File: rtl/mod_step_unit.sv
// Combinational step datapath: given the current count and effective step,
// produce the next count and flag a wrap/saturate event.
module mod_step_unit
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SAT_MODE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] s,
  input  logic             up_down,
  output logic [WIDTH-1:0] next_count,
  output logic             event_flag
);

  // Modulus may be 2**WIDTH, so it needs the extra bit.
  localparam logic [WIDTH:0] MODULUS = {1'b0, MAX_VAL} + (WIDTH+1)'(1);

  logic [WIDTH:0] sum;

  always_comb begin
    sum        = {1'b0, count} + {1'b0, s};
    next_count = count;
    event_flag = 1'b0;
    if (up_down) begin
      if (sum <= {1'b0, MAX_VAL}) begin
        next_count = sum[WIDTH-1:0];
      end else begin
        event_flag = 1'b1;
        next_count = (SAT_MODE == MODE_SAT) ? MAX_VAL : WIDTH'(sum - MODULUS);
      end
    end else begin
      if (s <= count) begin
        next_count = count - s;
      end else begin
        event_flag = 1'b1;
        next_count = (SAT_MODE == MODE_SAT) ? '0
                   : WIDTH'({1'b0, count} + MODULUS - {1'b0, s});
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap or saturate overflow handling,
// synchronous load, terminal-count output and sticky overflow flag.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SAT_MODE = MODE_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             overflow
);

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] next_count;
  logic             step_event;
  logic [WIDTH-1:0] load_clamped;

  assign s_eff        = (step > MAX_VAL) ? MAX_VAL : step;
  assign load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;

  mod_step_unit #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SAT_MODE (SAT_MODE)
  ) u_step (
    .count      (count_out),
    .s          (s_eff),
    .up_down    (up_down),
    .next_count (next_count),
    .event_flag (step_event)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      count_out <= '0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        count_out <= load_clamped;
      end else if (enable) begin
        count_out <= next_count;
      end
      // A real event beats clear_ovf; load suppresses the event entirely.
      if (!load && enable && step_event) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  assign tc = ~reset & enable & ~load &
              ((up_down & (count_out == MAX_VAL)) | (~up_down & (count_out == '0)));

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: four instances covering full-range
// wrap, modulus-10 wrap, saturate, and modulus-100 load clamping.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst [4];
  logic       en  [4];
  logic       ud  [4];
  logic [7:0] stp [4];
  logic       ld  [4];
  logic [7:0] lv  [4];
  logic       clr [4];
  logic [7:0] cnt [4];
  logic       tcv [4];
  logic       ovf [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // 0: WIDTH=8 wrap, 1: MAX_VAL=9 wrap, 2: WIDTH=8 saturate, 3: MAX_VAL=99 wrap
  updown_counter_param #(.WIDTH(8), .MAX_VAL(8'd255), .SAT_MODE(1'b0)) dut0 (
    .clock(clk), .reset(rst[0]), .enable(en[0]), .up_down(ud[0]), .step(stp[0]),
    .load(ld[0]), .load_value(lv[0]), .clear_ovf(clr[0]),
    .count_out(cnt[0]), .tc(tcv[0]), .overflow(ovf[0]));
  updown_counter_param #(.WIDTH(8), .MAX_VAL(8'd9), .SAT_MODE(1'b0)) dut1 (
    .clock(clk), .reset(rst[1]), .enable(en[1]), .up_down(ud[1]), .step(stp[1]),
    .load(ld[1]), .load_value(lv[1]), .clear_ovf(clr[1]),
    .count_out(cnt[1]), .tc(tcv[1]), .overflow(ovf[1]));
  updown_counter_param #(.WIDTH(8), .MAX_VAL(8'd255), .SAT_MODE(1'b1)) dut2 (
    .clock(clk), .reset(rst[2]), .enable(en[2]), .up_down(ud[2]), .step(stp[2]),
    .load(ld[2]), .load_value(lv[2]), .clear_ovf(clr[2]),
    .count_out(cnt[2]), .tc(tcv[2]), .overflow(ovf[2]));
  updown_counter_param #(.WIDTH(8), .MAX_VAL(8'd99), .SAT_MODE(1'b0)) dut3 (
    .clock(clk), .reset(rst[3]), .enable(en[3]), .up_down(ud[3]), .step(stp[3]),
    .load(ld[3]), .load_value(lv[3]), .clear_ovf(clr[3]),
    .count_out(cnt[3]), .tc(tcv[3]), .overflow(ovf[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int d);
    en[d] = 1'b0; ud[d] = 1'b1; stp[d] = 8'd0; ld[d] = 1'b0;
    lv[d] = 8'd0; clr[d] = 1'b0; rst[d] = 1'b0;
  endtask

  task automatic do_load(input int d, input logic [7:0] v);
    idle(d);
    ld[d] = 1'b1; lv[d] = v;
    tick();
    ld[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      idle(d);
      rst[d] = 1'b1;
    end
    tick();
    // tc must stay low during reset even though down+count==0 would assert it
    en[0] = 1'b1; ud[0] = 1'b0;
    #1 chk("t1_tc_in_reset", int'(tcv[0]), 0);
    tick();
    for (int d = 0; d < 4; d++) begin
      chk("reset_count", int'(cnt[d]), 0);
      chk("reset_ovf", int'(ovf[d]), 0);
      idle(d);
    end

    // Test 1: full 8-bit up count with wrap
    en[0] = 1'b1; ud[0] = 1'b1; stp[0] = 8'd1;
    #1 chk("t1_tc_at0", int'(tcv[0]), 0);
    for (int i = 1; i <= 255; i++) begin
      tick();
      chk("t1_count", int'(cnt[0]), i);
    end
    chk("t1_tc_at255", int'(tcv[0]), 1);
    chk("t1_ovf_before_wrap", int'(ovf[0]), 0);
    tick();
    chk("t1_wrap_count", int'(cnt[0]), 0);
    chk("t1_wrap_ovf", int'(ovf[0]), 1);

    // Test 5: clear_ovf alone, then clear_ovf coinciding with a wrap event
    idle(0);
    clr[0] = 1'b1;
    tick();
    chk("t5_clear_alone", int'(ovf[0]), 0);
    do_load(0, 8'd255);
    chk("t5_load255", int'(cnt[0]), 255);
    en[0] = 1'b1; ud[0] = 1'b1; stp[0] = 8'd1; clr[0] = 1'b1;
    tick();
    chk("t5_wrap_count", int'(cnt[0]), 0);
    chk("t5_clear_vs_event", int'(ovf[0]), 1);

    // Test 6: reset mid-count aborts the step, then hold with enable low
    do_load(0, 8'd37);
    chk("t6_load37", int'(cnt[0]), 37);
    en[0] = 1'b1; ud[0] = 1'b1; stp[0] = 8'd1; rst[0] = 1'b1;
    tick();
    chk("t6_reset_count", int'(cnt[0]), 0);
    chk("t6_reset_ovf", int'(ovf[0]), 0);
    idle(0);
    ud[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_hold_count", int'(cnt[0]), 0);
      chk("t6_hold_tc", int'(tcv[0]), 0);
    end

    // Test 2: modulus 10, wrap
    en[1] = 1'b1; ud[1] = 1'b1; stp[1] = 8'd3;
    tick(); chk("t2_3", int'(cnt[1]), 3); chk("t2_ovf3", int'(ovf[1]), 0);
    tick(); chk("t2_6", int'(cnt[1]), 6);
    tick(); chk("t2_9", int'(cnt[1]), 9); chk("t2_ovf9", int'(ovf[1]), 0);
    chk("t2_tc9", int'(tcv[1]), 1);
    tick(); chk("t2_2", int'(cnt[1]), 2); chk("t2_ovf2", int'(ovf[1]), 1);
    ud[1] = 1'b0; stp[1] = 8'd4;
    tick(); chk("t2_down8", int'(cnt[1]), 8); chk("t2_ovf_stays", int'(ovf[1]), 1);
    // step 15 clamps to 9: 8 - 9 wraps to 9
    stp[1] = 8'd15;
    tick(); chk("t2_clamp_step", int'(cnt[1]), 9);
    idle(1);

    // Test 3: saturate mode
    do_load(2, 8'd250);
    en[2] = 1'b1; ud[2] = 1'b1; stp[2] = 8'd10;
    tick(); chk("t3_sat255", int'(cnt[2]), 255); chk("t3_ovf", int'(ovf[2]), 1);
    clr[2] = 1'b1;
    tick(); chk("t3_hold255", int'(cnt[2]), 255);
    chk("t3_event_at_limit", int'(ovf[2]), 1);
    en[2] = 1'b0;
    tick(); chk("t3_cleared", int'(ovf[2]), 0);
    do_load(2, 8'd100);
    en[2] = 1'b1; ud[2] = 1'b0; stp[2] = 8'd200;
    tick(); chk("t3_sat0", int'(cnt[2]), 0); chk("t3_ovf_down", int'(ovf[2]), 1);
    idle(2);
    clr[2] = 1'b1;
    tick();
    en[2] = 1'b1; ud[2] = 1'b0; stp[2] = 8'd0; clr[2] = 1'b0;
    #1 chk("t3_tc_step0", int'(tcv[2]), 1);
    tick(); chk("t3_step0_hold", int'(cnt[2]), 0); chk("t3_step0_noevt", int'(ovf[2]), 0);
    idle(2);

    // Test 4: load clamping and load-over-enable priority
    do_load(3, 8'd200);
    chk("t4_clamp99", int'(cnt[3]), 99);
    ld[3] = 1'b1; lv[3] = 8'd10; en[3] = 1'b1; ud[3] = 1'b1; stp[3] = 8'd5;
    #1 chk("t4_tc_load", int'(tcv[3]), 0);
    tick(); chk("t4_load_wins", int'(cnt[3]), 10); chk("t4_no_ovf", int'(ovf[3]), 0);
    ld[3] = 1'b0;
    tick(); chk("t4_step", int'(cnt[3]), 15);
    do_load(3, 8'd98);
    en[3] = 1'b1; ud[3] = 1'b1; stp[3] = 8'd5;
    tick(); chk("t4_wrap", int'(cnt[3]), 3); chk("t4_wrap_ovf", int'(ovf[3]), 1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
